// File: rtl/kv_req_arb.sv
// kv_req_arb: two-requester round-robin arbiter feeding a shared in-order key/value DB port.
// Define KV_ARB_STATS_EN to build the saturating per-requester drop counters.
module kv_req_arb #(
  parameter int KEY_SIZE = 96,
  parameter int QDEPTH   = 4,
  parameter int MAX_OUT  = 8
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic                req0_valid,
  input  logic [KEY_SIZE-1:0] req0_key,
  input  logic [3:0]          req0_flag,
  input  logic                req1_valid,
  input  logic [KEY_SIZE-1:0] req1_key,
  input  logic [3:0]          req1_flag,
  output logic                rsp0_valid,
  output logic [3:0]          rsp0_flag,
  output logic                rsp1_valid,
  output logic [3:0]          rsp1_flag,
  output logic                db_in_valid,
  input  logic                db_in_ready,
  output logic [KEY_SIZE-1:0] db_in_key,
  output logic [3:0]          db_in_flag,
  input  logic                db_out_valid,
  input  logic [3:0]          db_out_flag,
  output logic [15:0]         drop0_cnt,
  output logic [15:0]         drop1_cnt,
  output logic                orphan_err
);
  localparam int QW = $clog2(QDEPTH);
  localparam int TW = $clog2(MAX_OUT);
  localparam int EW = KEY_SIZE + 4;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;
  logic gnt, prio, gnt_next, hs, tag_pop, tag_id;
  logic [1:0] req_valid, push, pop, full, nempty;
  logic [TW:0] outstanding;
  logic [TW-1:0] t_wr, t_rd;
  logic tag_mem [MAX_OUT];
  assign req_valid = {req1_valid, req0_valid};
  assign hs = db_in_valid && db_in_ready;
  assign gnt_next = &nempty ? prio : nempty[1];
  assign tag_pop = db_out_valid && outstanding != '0;
  assign tag_id = tag_mem[t_rd];
  for (genvar n = 0; n < 2; n++) begin : g_q
    logic [EW-1:0] mem [QDEPTH];
    logic [EW-1:0] hd;
    logic [QW-1:0] wr, rd;
    logic [QW:0] cnt;
    logic [15:0] dcnt;
    assign hd = mem[rd];
    assign full[n] = cnt == (QW+1)'(QDEPTH);
    assign nempty[n] = cnt != '0;
    assign pop[n] = hs && gnt == 1'(n);
    // a full queue still accepts a push when its head leaves in the same cycle
    assign push[n] = req_valid[n] && (!full[n] || pop[n]);
    always_ff @(posedge clk156)
      if (push[n]) mem[wr] <= (n == 1) ? {req1_key, req1_flag} : {req0_key, req0_flag};
    always_ff @(posedge clk156 or negedge eth_rst_n)
      if (!eth_rst_n) begin
        wr  <= '0;
        rd  <= '0;
        cnt <= '0;
      end else begin
        wr  <= wr + QW'(push[n]);
        rd  <= rd + QW'(pop[n]);
        cnt <= cnt + (QW+1)'(push[n]) - (QW+1)'(pop[n]);
      end
`ifdef KV_ARB_STATS_EN
    always_ff @(posedge clk156 or negedge eth_rst_n)
      if (!eth_rst_n) dcnt <= '0;
      else if (req_valid[n] && !push[n] && dcnt != 16'hFFFF) dcnt <= dcnt + 16'd1;
`else
    assign dcnt = '0;
`endif
  end
  assign drop0_cnt = g_q[0].dcnt;
  assign drop1_cnt = g_q[1].dcnt;
  always_ff @(posedge clk156)
    if (hs) tag_mem[t_wr] <= gnt;
  // tag FIFO occupancy doubles as the outstanding count
  always_ff @(posedge clk156 or negedge eth_rst_n)
    if (!eth_rst_n) begin
      t_wr        <= '0;
      t_rd        <= '0;
      outstanding <= '0;
      orphan_err  <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_flag   <= '0;
      rsp1_flag   <= '0;
    end else begin
      t_wr        <= t_wr + TW'(hs);
      t_rd        <= t_rd + TW'(tag_pop);
      outstanding <= outstanding + (TW+1)'(hs) - (TW+1)'(tag_pop);
      orphan_err  <= orphan_err || (db_out_valid && !tag_pop);
      rsp0_valid  <= tag_pop && !tag_id;
      rsp1_valid  <= tag_pop && tag_id;
      rsp0_flag   <= tag_pop && !tag_id ? db_out_flag : rsp0_flag;
      rsp1_flag   <= tag_pop && tag_id ? db_out_flag : rsp1_flag;
    end
  always_ff @(posedge clk156 or negedge eth_rst_n)
    if (!eth_rst_n) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      prio        <= 1'b0;
      db_in_valid <= 1'b0;
      db_in_key   <= '0;
      db_in_flag  <= '0;
    end else if (state == IDLE) begin
      if (|nempty && outstanding < (TW+1)'(MAX_OUT)) begin
        state       <= ISSUE;
        gnt         <= gnt_next;
        prio        <= !gnt_next;
        db_in_valid <= 1'b1;
        {db_in_key, db_in_flag} <= gnt_next ? g_q[1].hd : g_q[0].hd;
      end
    end else if (db_in_ready) begin
      state       <= IDLE;
      db_in_valid <= 1'b0;
    end
endmodule

// File: tb/tb_kv_req_arb.sv
// tb_kv_req_arb: directed self-checking bench for kv_req_arb.
module tb_kv_req_arb;
  localparam int KS = 96;
  localparam logic [KS-1:0] K1 = 96'h123456789ABCDEF012345678;
  localparam logic [KS-1:0] KA = 96'hAAAA0000AAAA0000AAAA0000;
  localparam logic [KS-1:0] KB = 96'hBBBB1111BBBB1111BBBB1111;
`ifdef KV_ARB_STATS_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif
  logic clk156 = 1'b0, eth_rst_n = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [KS-1:0] req0_key = '0, req1_key = '0;
  logic [3:0] req0_flag = '0, req1_flag = '0;
  logic rsp0_valid, rsp1_valid, db_in_valid, orphan_err;
  logic [3:0] rsp0_flag, rsp1_flag, db_in_flag;
  logic db_in_ready = 1'b0, db_out_valid = 1'b0;
  logic [3:0] db_out_flag = '0;
  logic [KS-1:0] db_in_key;
  logic [15:0] drop0_cnt, drop1_cnt;
  int checks = 0, errors = 0;

  kv_req_arb dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .req0_valid(req0_valid), .req0_key(req0_key), .req0_flag(req0_flag),
    .req1_valid(req1_valid), .req1_key(req1_key), .req1_flag(req1_flag),
    .rsp0_valid(rsp0_valid), .rsp0_flag(rsp0_flag),
    .rsp1_valid(rsp1_valid), .rsp1_flag(rsp1_flag),
    .db_in_valid(db_in_valid), .db_in_ready(db_in_ready),
    .db_in_key(db_in_key), .db_in_flag(db_in_flag),
    .db_out_valid(db_out_valid), .db_out_flag(db_out_flag),
    .drop0_cnt(drop0_cnt), .drop1_cnt(drop1_cnt), .orphan_err(orphan_err)
  );

  always #5 clk156 = ~clk156;

  task automatic cycle;
    @(posedge clk156);
    #1;
  endtask

  task automatic do_reset;
    eth_rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    db_out_valid = 1'b0;
    db_in_ready = 1'b0;
    cycle;
    cycle;
    eth_rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2 eth_rst_n = 1'b0;
    #1;
    checks++; if (db_in_valid !== 1'b0) begin errors++; $display("FAIL reset_db_in_valid got %b want 0", db_in_valid); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid}); end
    checks++; if ({drop0_cnt, drop1_cnt} !== 32'd0) begin errors++; $display("FAIL reset_drop_cnt got %h want 0", {drop0_cnt, drop1_cnt}); end
    checks++; if ({orphan_err, rsp0_flag, rsp1_flag, db_in_flag} !== 13'd0) begin errors++; $display("FAIL reset_misc got %h want 0", {orphan_err, rsp0_flag, rsp1_flag, db_in_flag}); end
    cycle;
    eth_rst_n = 1'b1;
  endtask

  task automatic test_basic;
    do_reset;
    db_in_ready = 1'b1;
    req0_valid = 1'b1; req0_key = K1; req0_flag = 4'b0011;
    cycle;
    req0_valid = 1'b0;
    checks++; if (db_in_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", db_in_valid); end
    cycle;
    checks++; if (db_in_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", db_in_valid); end
    checks++; if ({db_in_key, db_in_flag} !== {K1, 4'b0011}) begin errors++; $display("FAIL basic_key_flag got %h want %h", {db_in_key, db_in_flag}, {K1, 4'b0011}); end
    cycle;
    checks++; if (db_in_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", db_in_valid); end
    db_out_valid = 1'b1; db_out_flag = 4'b0100;
    cycle;
    db_out_valid = 1'b0;
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errors++; $display("FAIL basic_rsp_valid got %b want 10", {rsp0_valid, rsp1_valid}); end
    checks++; if (rsp0_flag !== 4'b0100) begin errors++; $display("FAIL basic_rsp_flag got %b want 0100", rsp0_flag); end
    cycle;
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL basic_rsp_pulse got %b want 00", {rsp0_valid, rsp1_valid}); end
  endtask

  task automatic test_round_robin;
    do_reset;
    db_in_ready = 1'b1;
    req0_valid = 1'b1; req0_key = KA; req0_flag = 4'h1;
    req1_valid = 1'b1; req1_key = KB; req1_flag = 4'h2;
    cycle;
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle;
    checks++; if ({db_in_valid, db_in_key, db_in_flag} !== {1'b1, KA, 4'h1}) begin errors++; $display("FAIL rr_first got %h want %h", {db_in_valid, db_in_key, db_in_flag}, {1'b1, KA, 4'h1}); end
    cycle;
    checks++; if (db_in_valid !== 1'b0) begin errors++; $display("FAIL rr_gap got %b want 0", db_in_valid); end
    cycle;
    checks++; if ({db_in_valid, db_in_key, db_in_flag} !== {1'b1, KB, 4'h2}) begin errors++; $display("FAIL rr_second got %h want %h", {db_in_valid, db_in_key, db_in_flag}, {1'b1, KB, 4'h2}); end
    cycle;
    db_out_valid = 1'b1; db_out_flag = 4'h5;
    cycle;
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errors++; $display("FAIL rr_rsp0_valid got %b want 10", {rsp0_valid, rsp1_valid}); end
    checks++; if (rsp0_flag !== 4'h5) begin errors++; $display("FAIL rr_rsp0_flag got %h want 5", rsp0_flag); end
    db_out_flag = 4'h6;
    cycle;
    db_out_valid = 1'b0;
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin errors++; $display("FAIL rr_rsp1_valid got %b want 01", {rsp0_valid, rsp1_valid}); end
    checks++; if (rsp1_flag !== 4'h6) begin errors++; $display("FAIL rr_rsp1_flag got %h want 6", rsp1_flag); end
    cycle;
    checks++; if ({rsp0_valid, rsp1_valid, orphan_err} !== 3'b000) begin errors++; $display("FAIL rr_quiet got %b want 000", {rsp0_valid, rsp1_valid, orphan_err}); end
  endtask

  task automatic test_drop;
    int exp_keys [4] = '{2, 3, 4, 6};
    do_reset;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req0_key = KS'(i + 1); req0_flag = 4'(i);
      cycle;
    end
    checks++; if (drop0_cnt !== EXP_DROP) begin errors++; $display("FAIL drop_cnt got %0d want %0d", drop0_cnt, EXP_DROP); end
    checks++; if ({db_in_valid, db_in_key} !== {1'b1, KS'(1)}) begin errors++; $display("FAIL drop_head got %h want %h", {db_in_valid, db_in_key}, {1'b1, KS'(1)}); end
    req0_key = KS'(6); db_in_ready = 1'b1;
    cycle;
    req0_valid = 1'b0;
    checks++; if (db_in_valid !== 1'b0) begin errors++; $display("FAIL drop_hs got %b want 0", db_in_valid); end
    for (int j = 0; j < 4; j++) begin
      cycle;
      checks++; if ({db_in_valid, db_in_key} !== {1'b1, KS'(exp_keys[j])}) begin errors++; $display("FAIL drop_order%0d got %h want %h", j, {db_in_valid, db_in_key}, {1'b1, KS'(exp_keys[j])}); end
      cycle;
    end
    cycle;
    checks++; if (db_in_valid !== 1'b0) begin errors++; $display("FAIL drop_empty got %b want 0", db_in_valid); end
    checks++; if ({drop0_cnt, drop1_cnt} !== {EXP_DROP, 16'd0}) begin errors++; $display("FAIL drop_cnt_final got %h want %h", {drop0_cnt, drop1_cnt}, {EXP_DROP, 16'd0}); end
  endtask

  task automatic test_max_out;
    int n = 0;
    do_reset;
    db_in_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req0_valid = 1'b1; req0_key = KS'(i + 1);
      cycle;
      if (db_in_valid && db_in_ready) n++;
      req0_valid = 1'b0;
      cycle;
      if (db_in_valid && db_in_ready) n++;
    end
    repeat (6) begin
      cycle;
      if (db_in_valid && db_in_ready) n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL max_out_issues got %0d want 8", n); end
    db_out_valid = 1'b1; db_out_flag = 4'h7;
    cycle;
    db_out_valid = 1'b0;
    checks++; if ({db_in_valid, rsp0_valid} !== 2'b01) begin errors++; $display("FAIL max_out_rsp got %b want 01", {db_in_valid, rsp0_valid}); end
    cycle;
    checks++; if ({db_in_valid, db_in_key} !== {1'b1, KS'(9)}) begin errors++; $display("FAIL max_out_ninth got %h want %h", {db_in_valid, db_in_key}, {1'b1, KS'(9)}); end
  endtask

  task automatic test_orphan;
    do_reset;
    db_out_valid = 1'b1; db_out_flag = 4'h9;
    cycle;
    db_out_valid = 1'b0;
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orphan_set got %b want 1", orphan_err); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL orphan_rsp got %b want 00", {rsp0_valid, rsp1_valid}); end
    cycle;
    checks++; if ({orphan_err, rsp0_valid, rsp1_valid} !== 3'b100) begin errors++; $display("FAIL orphan_sticky got %b want 100", {orphan_err, rsp0_valid, rsp1_valid}); end
  endtask

  task automatic test_reset_mid_issue;
    do_reset;
    req0_valid = 1'b1; req0_key = K1; req0_flag = 4'h3;
    cycle;
    req0_valid = 1'b0;
    cycle;
    checks++; if (db_in_valid !== 1'b1) begin errors++; $display("FAIL mid_issue_valid got %b want 1", db_in_valid); end
    #2 eth_rst_n = 1'b0;
    #1;
    checks++; if (db_in_valid !== 1'b0) begin errors++; $display("FAIL mid_issue_async got %b want 0", db_in_valid); end
    cycle;
    eth_rst_n = 1'b1;
    db_in_ready = 1'b1;
    repeat (3) cycle;
    checks++; if (db_in_valid !== 1'b0) begin errors++; $display("FAIL mid_issue_abandon got %b want 0", db_in_valid); end
    db_out_valid = 1'b1; db_out_flag = 4'h2;
    cycle;
    db_out_valid = 1'b0;
    checks++; if ({orphan_err, rsp0_valid, rsp1_valid} !== 3'b100) begin errors++; $display("FAIL mid_issue_orphan got %b want 100", {orphan_err, rsp0_valid, rsp1_valid}); end
    cycle;
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL mid_issue_quiet got %b want 00", {rsp0_valid, rsp1_valid}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_drop;
    test_max_out;
    test_orphan;
    test_reset_mid_issue;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
